// File: rtl/sdram_arbiter.sv
// Two-master arbiter in front of a single SDRAM controller port: master 0 has fixed
// priority, and master 1 wins after MAX_WAIT lost arbitrations. One transaction per IDLE visit.
module sdram_arbiter #(
  parameter int ADDR_W   = 23,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic                m0_instr,
  output logic [2*DATA_W-1:0] m0_rdata,
  output logic                m0_busy,
  output logic                m0_cack,
  output logic                m0_ready,
  output logic                m0_err,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic                m1_read,
  input  logic                m1_write,
  output logic [2*DATA_W-1:0] m1_rdata,
  output logic                m1_busy,
  output logic                m1_cack,
  output logic                m1_ready,
  output logic                m1_err,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic                s_read,
  output logic                s_write,
  output logic                s_instr,
  input  logic [2*DATA_W-1:0] s_rdata,
  input  logic                s_busy,
  input  logic                s_cack,
  input  logic                s_ready
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

  localparam int WC_W = $clog2(MAX_WAIT + 1);
  localparam int TM_W = $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] WAIT_MAX = WC_W'(MAX_WAIT);
  localparam logic [TM_W-1:0] TM_LAST  = TM_W'(TIMEOUT - 1);

  state_t              state_reg, state_next;
  logic                grant_reg, op_wr_reg, instr_reg;
  logic                s_read_reg, s_write_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [WC_W-1:0]     wait_cnt_reg;
  logic [TM_W-1:0]     timer_reg;
  logic [1:0][2*DATA_W-1:0] rdata_reg;
  logic [1:0]          cack_reg, ready_reg, err_reg;
  logic [1:0]          cack_next, ready_next, err_next;
  logic [1:0]          busy, gnt;
  logic                req0, req1, grant_sel, tm_expired;

  assign req0       = m0_read | m0_write;
  assign req1       = m1_read | m1_write;
  assign grant_sel  = req1 & (~req0 | (wait_cnt_reg >= WAIT_MAX));
  assign tm_expired = (timer_reg == TM_LAST);
  assign gnt        = {grant_reg, ~grant_reg};

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // A completing handshake takes precedence over a timeout in the same cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req0 | req1) state_next = ISSUE;
      ISSUE:   if (s_cack) state_next = (op_wr_reg | s_ready) ? IDLE : WAIT_RD;
               else if (tm_expired) state_next = IDLE;
      WAIT_RD: if (s_ready | tm_expired) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cack_next  = '0;
    ready_next = '0;
    err_next   = '0;
    case (state_reg)
      ISSUE: begin
        if (s_cack) begin
          cack_next[grant_reg] = 1'b1;
          if (!op_wr_reg && s_ready) ready_next[grant_reg] = 1'b1;
        end else if (tm_expired) begin
          err_next[grant_reg] = 1'b1;
        end
      end
      WAIT_RD: begin
        if (s_ready)         ready_next[grant_reg] = 1'b1;
        else if (tm_expired) err_next[grant_reg]   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_reg    <= 1'b0;
      op_wr_reg    <= 1'b0;
      instr_reg    <= 1'b0;
      s_read_reg   <= 1'b0;
      s_write_reg  <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      wait_cnt_reg <= '0;
      timer_reg    <= '0;
      rdata_reg    <= '0;
      cack_reg     <= '0;
      ready_reg    <= '0;
      err_reg      <= '0;
    end else begin
      if (state_reg == IDLE && (req0 | req1)) begin
        grant_reg   <= grant_sel;
        addr_reg    <= grant_sel ? m1_addr : m0_addr;
        wdata_reg   <= grant_sel ? m1_wdata : m0_wdata;
        op_wr_reg   <= grant_sel ? m1_write : m0_write;
        instr_reg   <= ~grant_sel & m0_instr;
        s_write_reg <= grant_sel ? m1_write : m0_write;
        s_read_reg  <= grant_sel ? (m1_read & ~m1_write) : (m0_read & ~m0_write);
        timer_reg   <= '0;
        if (grant_sel)
          wait_cnt_reg <= '0;
        else if (req1 && wait_cnt_reg != WAIT_MAX)
          wait_cnt_reg <= wait_cnt_reg + 1'b1;
      end else if (state_reg != IDLE) begin
        timer_reg <= timer_reg + 1'b1;
        if (state_reg == ISSUE && state_next != ISSUE) begin
          s_read_reg  <= 1'b0;
          s_write_reg <= 1'b0;
        end
      end
      for (int i = 0; i < 2; i++)
        if (ready_next[i]) rdata_reg[i] <= s_rdata;
      cack_reg  <= cack_next;
      ready_reg <= ready_next;
      err_reg   <= err_next;
    end
  end

  // A master is busy while the other one owns the port, or while its own command awaits cack.
  for (genvar gi = 0; gi < 2; gi++) begin : g_busy
    assign busy[gi] = s_busy | ((state_reg != IDLE) & ~gnt[gi]) |
                      ((state_reg == ISSUE) & gnt[gi]);
  end

  assign s_addr   = addr_reg;
  assign s_wdata  = wdata_reg;
  assign s_read   = s_read_reg;
  assign s_write  = s_write_reg;
  assign s_instr  = instr_reg;
  assign m0_rdata = rdata_reg[0];
  assign m1_rdata = rdata_reg[1];
  assign m0_busy  = busy[0];
  assign m1_busy  = busy[1];
  assign m0_cack  = cack_reg[0];
  assign m1_cack  = cack_reg[1];
  assign m0_ready = ready_reg[0];
  assign m1_ready = ready_reg[1];
  assign m0_err   = err_reg[0];
  assign m1_err   = err_reg[1];

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: table-driven transactions, hand-written corner
// sequences (arbitration order, timeout, reset), and randomized rounds against an arbitration model.
module tb_sdram_arbiter;

  localparam int AW = 23;
  localparam int DW = 16;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0, s_addr;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0, s_wdata;
  logic          m0_read = 0, m0_write = 0, m0_instr = 0, m1_read = 0, m1_write = 0;
  logic [31:0]   m0_rdata, m1_rdata;
  logic [31:0]   s_rdata = '0;
  logic          m0_busy, m0_cack, m0_ready, m0_err;
  logic          m1_busy, m1_cack, m1_ready, m1_err;
  logic          s_read, s_write, s_instr;
  logic          s_busy = 0, s_cack = 0, s_ready = 0;

  always #5 clk = ~clk;

  sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_read(m0_read), .m0_write(m0_write),
    .m0_instr(m0_instr), .m0_rdata(m0_rdata), .m0_busy(m0_busy), .m0_cack(m0_cack),
    .m0_ready(m0_ready), .m0_err(m0_err),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_read(m1_read), .m1_write(m1_write),
    .m1_rdata(m1_rdata), .m1_busy(m1_busy), .m1_cack(m1_cack),
    .m1_ready(m1_ready), .m1_err(m1_err),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_read(s_read), .s_write(s_write),
    .s_instr(s_instr), .s_rdata(s_rdata), .s_busy(s_busy), .s_cack(s_cack), .s_ready(s_ready)
  );

  typedef struct {
    bit          m;
    bit          wr;
    bit          both;
    bit          rival;
    bit          instr;
    logic [22:0] addr;
    logic [15:0] wdata;
    int          d;
    int          r;
    logic [31:0] rdata;
    int          exp_hi;
    int          exp_rdy;
    bit          exp_instr;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input bit m, input bit rd, input bit wr, input logic [22:0] a,
                           input logic [15:0] wd, input bit ins);
    if (!m) begin
      m0_read = rd; m0_write = wr; m0_addr = a; m0_wdata = wd; m0_instr = ins;
    end else begin
      m1_read = rd; m1_write = wr; m1_addr = a; m1_wdata = wd;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [13:0] idle_outputs();
    return {s_read, s_write, s_instr, m0_cack, m0_ready, m0_err, m1_cack, m1_ready, m1_err,
            m0_busy, m1_busy, 3'b000};
  endfunction

  // Called at a negedge with the arbiter idle; the controller responds with cack in the
  // d-th command cycle and ready r cycles after that (r=0: same cycle as cack).
  task automatic run_txn(input vec_t v);
    int hi = 0, ck = 0, rdy = 0, ck_at = -1, rdy_at = -1, oth = 0, er = 0;
    int unstable = 0, busy_bad = 0, align_bad = 0;
    logic [31:0] other_before;
    bit in_issue, active, g_cack, g_ready, g_busy, o_busy;
    other_before = v.m ? m0_rdata : m1_rdata;
    drive_req(v.m, !v.wr | v.both, v.wr, v.addr, v.wdata, v.instr);
    if (v.rival) drive_req(!v.m, 1'b1, 1'b0, ~v.addr, ~v.wdata, 1'b0);
    for (int c = 1; c <= v.d + v.r + 4; c++) begin
      @(negedge clk);
      s_cack  = (c == v.d);
      s_ready = !v.wr && (c == v.d + v.r);
      s_rdata = s_ready ? v.rdata : ~v.rdata;
      in_issue = (c <= v.d);
      active   = in_issue || (!v.wr && c <= v.d + v.r);
      g_busy  = v.m ? m1_busy : m0_busy;
      o_busy  = v.m ? m0_busy : m1_busy;
      g_cack  = v.m ? m1_cack : m0_cack;
      g_ready = v.m ? m1_ready : m0_ready;
      if (g_busy !== in_issue || o_busy !== active) busy_bad++;
      if (v.wr ? s_read : s_write) unstable++;
      if (v.wr ? s_write : s_read) begin
        hi++;
        if (s_addr !== v.addr || s_wdata !== v.wdata || s_instr !== v.exp_instr) unstable++;
      end
      if (g_cack) begin
        ck++; ck_at = c;
        drive_req(0, 0, 0, '0, '0, 0);
        drive_req(1, 0, 0, '0, '0, 0);
      end
      if (g_ready) begin
        rdy++; rdy_at = c;
        if ((v.m ? m1_rdata : m0_rdata) !== v.rdata) align_bad++;
      end
      if (v.m ? (m0_cack | m0_ready) : (m1_cack | m1_ready)) oth++;
      if (m0_err | m1_err) er++;
    end
    s_cack = 0; s_ready = 0;
    drive_req(0, 0, 0, '0, '0, 0);
    drive_req(1, 0, 0, '0, '0, 0);
    $display("txn m%0d %s addr=%06h d=%0d r=%0d cmd=%0d cack=%0d ready=%0d", v.m,
             v.wr ? "wr" : "rd", v.addr, v.d, v.r, hi, ck, rdy);
    check("cmd_cycles", hi, v.exp_hi);
    check("cack_pulses", ck, 1);
    check("ready_pulses", rdy, v.exp_rdy);
    check("cmd_fields", unstable, 0);
    check("busy", busy_bad, 0);
    check("other_pulses", oth, 0);
    check("err_pulses", er, 0);
    check("other_rdata", v.m ? m0_rdata : m1_rdata, other_before);
    if (v.exp_rdy != 0) begin
      check("ready_offset", rdy_at - ck_at, v.r);
      check("ready_align", align_bad, 0);
      check("rdata", v.m ? m1_rdata : m0_rdata, v.rdata);
    end
  endtask

  initial begin
    vec_t vecs[7];
    vec_t v;
    bit   order[$];
    bit   exp_order[10];
    int   losses, hi, er, ck, rdy;
    bit   r0, r1, win;

    vecs[0] = '{0, 0, 0, 0, 0, 23'h000123, 16'h0000, 2, 3, 32'hDEADBEEF, 2, 1, 0};
    vecs[1] = '{1, 1, 0, 0, 0, 23'h000400, 16'hA5A5, 1, 0, 32'h0,        1, 0, 0};
    vecs[2] = '{0, 0, 0, 0, 1, 23'h0ABCDE, 16'h0000, 1, 0, 32'h12345678, 1, 1, 1};
    vecs[3] = '{1, 0, 0, 0, 1, 23'h7FFFFF, 16'h1111, 3, 1, 32'hCAFEF00D, 3, 1, 0};
    vecs[4] = '{0, 1, 1, 0, 0, 23'h155555, 16'h5A5A, 4, 0, 32'h0,        4, 0, 0};
    vecs[5] = '{0, 0, 0, 1, 0, 23'h2AAAAA, 16'h0F0F, 1, 2, 32'h87654321, 1, 1, 0};
    vecs[6] = '{0, 1, 0, 1, 1, 23'h000001, 16'hFFFF, 2, 0, 32'h0,        2, 0, 1};

    do_reset();
    check("reset_outputs", idle_outputs(), 14'h0);
    check("reset_rdata", {m0_rdata, m1_rdata}, 64'h0);

    for (int i = 0; i < 7; i++) run_txn(vecs[i]);

    // Both masters request continuously; master 1 gets in after MW consecutive losses.
    do_reset();
    losses = 0;
    for (int i = 0; i < 10; i++) begin
      exp_order[i] = (losses >= MW);
      losses = exp_order[i] ? 0 : ((losses + 1 > MW) ? MW : losses + 1);
    end
    drive_req(0, 0, 1, 23'h000010, 16'h0001, 0);
    drive_req(1, 0, 1, 23'h000020, 16'h0002, 0);
    for (int c = 0; c < 100 && order.size() < 10; c++) begin
      @(negedge clk);
      s_cack = s_write;
      if (m0_cack) order.push_back(1'b0);
      if (m1_cack) order.push_back(1'b1);
    end
    drive_req(0, 0, 0, '0, '0, 0);
    drive_req(1, 0, 0, '0, '0, 0);
    repeat (3) @(negedge clk);
    s_cack = 0;
    repeat (2) @(negedge clk);
    $display("arbitration order observed %0d grants", order.size());
    check("grant_count", order.size() >= 10, 1);
    for (int i = 0; i < 10 && i < order.size(); i++)
      check($sformatf("grant_order[%0d]", i), order[i], exp_order[i]);

    // Controller never acknowledges: abort after 255 command cycles with a single err.
    hi = 0; er = 0; ck = 0; rdy = 0;
    drive_req(0, 1, 0, 23'h003000, 16'h0, 0);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (s_read) hi++;
      if (m0_err) begin er++; drive_req(0, 0, 0, '0, '0, 0); end
      if (m0_cack) ck++;
      if (m0_ready) rdy++;
    end
    drive_req(0, 0, 0, '0, '0, 0);
    $display("timeout read: cmd=%0d err=%0d cack=%0d", hi, er, ck);
    check("timeout_cmd_cycles", hi, 255);
    check("timeout_err", er, 1);
    check("timeout_no_cack", ck + rdy, 0);
    run_txn('{0, 0, 0, 0, 0, 23'h003000, 16'h0, 2, 1, 32'h0BADF00D, 2, 1, 0});

    // Reset while a read waits for data; a late ready must not reach the master.
    drive_req(0, 1, 0, 23'h004444, 16'h0, 1);
    @(negedge clk); s_cack = 1;
    @(negedge clk); s_cack = 0; drive_req(0, 0, 0, '0, '0, 0);
    check("wait_rd_busy", {m0_busy, m1_busy}, 2'b01);
    rst_n = 0;
    @(negedge clk); rst_n = 1;
    check("midreset_outputs", idle_outputs(), 14'h0);
    check("midreset_rdata", {m0_rdata, m1_rdata}, 64'h0);
    s_ready = 1; s_rdata = 32'h11112222;
    @(negedge clk); s_ready = 0;
    rdy = 0;
    for (int c = 0; c < 3; c++) begin
      if (m0_ready | m1_ready) rdy++;
      @(negedge clk);
    end
    $display("mid-read reset: late readies=%0d", rdy);
    check("late_ready", rdy, 0);
    s_busy = 1;
    #1 check("busy_passthrough", {m0_busy, m1_busy}, 2'b11);
    s_busy = 0;
    @(negedge clk);

    // Randomized rounds against the arbitration model.
    do_reset();
    losses = 0;
    for (int n = 0; n < 40; n++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1;
      if (r0 && r1) begin
        win = (losses >= MW);
        losses = win ? 0 : ((losses + 1 > MW) ? MW : losses + 1);
      end else begin
        win = r1;
        if (r1) losses = 0;
      end
      v.m      = win;
      v.wr     = 1'($urandom_range(0, 1));
      v.both   = v.wr & 1'($urandom_range(0, 1));
      v.rival  = r0 & r1;
      v.instr  = 1'($urandom_range(0, 1));
      v.addr   = 23'($urandom);
      v.wdata  = 16'($urandom);
      v.d      = $urandom_range(1, 4);
      v.r      = $urandom_range(0, 3);
      v.rdata  = $urandom;
      v.exp_hi = v.d;
      v.exp_rdy = v.wr ? 0 : 1;
      v.exp_instr = !win & v.instr;
      run_txn(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
